// File: rtl/nes_joypad_ctrl.sv
// NES joypad sequencer: latches both pads, clocks out 8 buttons over the shared
// LATCH/CLK lines, and commits active-high button vectors with a one-cycle strobe.
//   state    | meaning
//   S_IDLE   | wait for poll timer or poll_req
//   S_LATCH  | jp_latch high, pads load parallel buttons
//   S_SETTLE | lines low, sample button A on last cycle
//   S_CLK_HI | jp_clk high, pads shift to next button
//   S_CLK_LO | jp_clk low, sample current button on last cycle
module nes_joypad_ctrl #(
  parameter int LATCH_CYCLES    = 1200,
  parameter int HALF_BIT_CYCLES = 600,
  parameter int IDLE_CYCLES     = 1666667
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       jp_data1_in,
  input  logic       jp_data2_in,
  input  logic       poll_req,
  output logic       jp_latch,
  output logic       jp_clk,
  output logic [7:0] jp1_state,
  output logic [7:0] jp2_state,
  output logic       poll_valid,
  output logic       busy
);

  localparam int CNT_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETTLE,
    S_CLK_HI,
    S_CLK_LO
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [1:0]    sync1_q, sync2_q;
  logic [7:0]    shift1_q, shift1_d, shift2_q, shift2_d;
  logic          commit_q, commit_d;
  logic [7:0]    jp1_q, jp1_d, jp2_q, jp2_d;
  logic          latch_q, latch_d, jclk_q, jclk_d, valid_q, valid_d;
  logic          pad1_pressed, pad2_pressed;

  assign pad1_pressed = ~sync1_q[1];
  assign pad2_pressed = ~sync2_q[1];

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift1_d = shift1_q;
    shift2_d = shift2_q;
    commit_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (timer_q == IDLE_LAST || poll_req) begin
          state_d = S_LATCH;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == HALF_LAST) begin
          shift1_d[0] = pad1_pressed;
          shift2_d[0] = pad2_pressed;
          state_d     = S_CLK_HI;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLK_HI: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_CLK_LO;
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLK_LO: begin
        if (cnt_q == HALF_LAST) begin
          shift1_d[idx_q] = pad1_pressed;
          shift2_d[idx_q] = pad2_pressed;
          cnt_d           = '0;
          if (idx_q == 3'd7) begin
            state_d  = S_IDLE;
            commit_d = 1'b1;
          end else begin
            state_d = S_CLK_HI;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin outputs follow the next state so they come straight from flops.
    latch_d = (state_d == S_LATCH);
    jclk_d  = (state_d == S_CLK_HI);
    // The last sample lands in the shift registers one edge before commit.
    valid_d = commit_q;
    jp1_d   = commit_q ? shift1_q : jp1_q;
    jp2_d   = commit_q ? shift2_q : jp2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      shift1_q <= '0;
      shift2_q <= '0;
      commit_q <= 1'b0;
      jp1_q    <= '0;
      jp2_q    <= '0;
      latch_q  <= 1'b0;
      jclk_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sync1_q  <= {sync1_q[0], jp_data1_in};
      sync2_q  <= {sync2_q[0], jp_data2_in};
      shift1_q <= shift1_d;
      shift2_q <= shift2_d;
      commit_q <= commit_d;
      jp1_q    <= jp1_d;
      jp2_q    <= jp2_d;
      latch_q  <= latch_d;
      jclk_q   <= jclk_d;
      valid_q  <= valid_d;
    end
  end

  assign jp_latch   = latch_q;
  assign jp_clk     = jclk_q;
  assign jp1_state  = jp1_q;
  assign jp2_state  = jp2_q;
  assign poll_valid = valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_nes_joypad_ctrl.sv
// Directed bench for nes_joypad_ctrl with a behavioural 4021-style pad model
// and a negedge monitor for line timing, strobe width and commit-only updates.
module tb_nes_joypad_ctrl;

  localparam int LAT  = 4;
  localparam int HALF = 4;
  localparam int IDLE = 20;
  localparam int TXN  = LAT + 15 * HALF + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       jp_data1_in, jp_data2_in;
  logic       poll_req = 1'b0;
  logic       jp_latch, jp_clk, poll_valid, busy;
  logic [7:0] jp1_state, jp2_state;

  nes_joypad_ctrl #(
    .LATCH_CYCLES(LAT),
    .HALF_BIT_CYCLES(HALF),
    .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .jp_data1_in(jp_data1_in),
    .jp_data2_in(jp_data2_in),
    .poll_req(poll_req),
    .jp_latch(jp_latch),
    .jp_clk(jp_clk),
    .jp1_state(jp1_state),
    .jp2_state(jp2_state),
    .poll_valid(poll_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Pad model: parallel load while latch is high, shift on jp_clk rise, data active-low.
  logic [7:0] btn1 = 8'h00, btn2 = 8'h00;
  logic [7:0] pad1_sr = 8'hFF, pad2_sr = 8'hFF;
  logic       pad_clk_prev = 1'b0;
  always @(posedge clk) begin
    if (jp_latch) begin
      pad1_sr <= ~btn1;
      pad2_sr <= ~btn2;
    end else if (jp_clk && !pad_clk_prev) begin
      pad1_sr <= {1'b1, pad1_sr[7:1]};
      pad2_sr <= {1'b1, pad2_sr[7:1]};
    end
    pad_clk_prev <= jp_clk;
  end
  assign jp_data1_in = pad1_sr[0];
  assign jp_data2_in = pad2_sr[0];

  // Monitor
  int   overlap_cnt = 0, pv_wide_cnt = 0, glitch_cnt = 0, bad_hi = 0, bad_lo = 0;
  int   since_latch = 0, pulses = 0, latch_len = 0, last_latch_len = 0;
  int   hi_len = 0, lo_len = 0, idle_since = 0, last_gap = 0, last_lat = 0, last_pulses = 0;
  int   pv_count = 0;
  logic latch_prev = 0, clk_prev = 0, pv_prev = 0, busy_prev = 0;
  logic [7:0] s1_prev = 0, s2_prev = 0;

  always @(negedge clk) begin
    if (rst) begin
      idle_since = 0;
      latch_prev = 0;
      clk_prev   = 0;
      pv_prev    = 0;
      busy_prev  = 0;
      s1_prev    = jp1_state;
      s2_prev    = jp2_state;
    end else begin
      if (jp_latch && jp_clk) overlap_cnt++;
      if (poll_valid && pv_prev) pv_wide_cnt++;
      if ((jp1_state != s1_prev || jp2_state != s2_prev) && !poll_valid) glitch_cnt++;
      if (!busy && busy_prev) idle_since = 0;
      else idle_since++;
      if (jp_latch && !latch_prev) begin
        since_latch = 0;
        pulses      = 0;
        latch_len   = 1;
        last_gap    = idle_since;
      end else begin
        since_latch++;
        if (jp_latch) latch_len++;
        else if (latch_prev) last_latch_len = latch_len;
      end
      if (jp_clk && !clk_prev) begin
        pulses++;
        if (pulses > 1 && lo_len != HALF) bad_lo++;
        hi_len = 1;
      end else if (jp_clk) begin
        hi_len++;
      end else if (clk_prev) begin
        if (hi_len != HALF) bad_hi++;
        lo_len = 1;
      end else begin
        lo_len++;
      end
      if (poll_valid) begin
        last_lat    = since_latch;
        last_pulses = pulses;
        pv_count++;
      end
      latch_prev = jp_latch;
      clk_prev   = jp_clk;
      pv_prev    = poll_valid;
      busy_prev  = busy;
      s1_prev    = jp1_state;
      s2_prev    = jp2_state;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pv(input string name, input int budget);
    int n = 0;
    step();
    while (!poll_valid && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (!poll_valid) begin
      errors++;
      $display("FAIL %s: poll_valid timeout, got 0, expected 1", name);
    end
  endtask

  task automatic check_poll(input string name, input logic [7:0] e1, input logic [7:0] e2,
                            input int egap);
    chk({name, " latency"}, last_lat, TXN);
    chk({name, " pulses"}, last_pulses, 7);
    chk({name, " latch_len"}, last_latch_len, LAT);
    chk({name, " gap"}, last_gap, egap);
    chk({name, " jp1"}, jp1_state, e1);
    chk({name, " jp2"}, jp2_state, e2);
  endtask

  task automatic pulse_req();
    poll_req = 1'b1;
    step();
    poll_req = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int pv_base;
    int n;
    vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{8'h09, 8'h80, 8'h09, 8'h80};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{8'h10, 8'hFF, 8'h10, 8'hFF};
    vecs[4] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};

    repeat (3) step();
    chk("rst jp_latch", jp_latch, 0);
    chk("rst jp_clk", jp_clk, 0);
    chk("rst jp1", jp1_state, 0);
    chk("rst jp2", jp2_state, 0);
    chk("rst poll_valid", poll_valid, 0);
    chk("rst busy", busy, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Free-running first poll with pads released.
    wait_pv("first", 200);
    #1;
    check_poll("first", 8'h00, 8'h00, IDLE);

    // poll_req at idle timer 5 (we sit just after IDLE entry + 1 cycle).
    for (int i = 0; i < 5; i++) begin
      btn1 = vecs[i].b1;
      btn2 = vecs[i].b2;
      repeat (4) step();
      pulse_req();
      wait_pv($sformatf("vec%0d", i), 200);
      #1;
      check_poll($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, 6);
    end

    // poll_req during CLK_HI is dropped; following poll waits a full idle period.
    btn1 = 8'h09;
    btn2 = 8'h80;
    n = 0;
    step();
    while (!jp_clk && n < 200) begin
      step();
      n++;
    end
    chk("reach clk_hi", jp_clk, 1);
    pv_base = pv_count;
    pulse_req();
    wait_pv("busyreq", 200);
    #1;
    check_poll("busyreq", 8'h09, 8'h80, IDLE);
    wait_pv("after busyreq", 200);
    #1;
    check_poll("after busyreq", 8'h09, 8'h80, IDLE);
    chk("busyreq pv count", pv_count - pv_base, 2);

    // poll_req coinciding with timer expiry starts a single poll.
    repeat (18) step();
    pulse_req();
    wait_pv("coincide", 200);
    #1;
    check_poll("coincide", 8'h09, 8'h80, IDLE);
    wait_pv("after coincide", 200);
    #1;
    check_poll("after coincide", 8'h09, 8'h80, IDLE);

    // Reset during CLK_HI of the third pulse after a committed 8'h09.
    btn2 = 8'h00;
    wait_pv("pre reset", 200);
    #1;
    check_poll("pre reset", 8'h09, 8'h00, IDLE);
    n = 0;
    step();
    while (!(jp_clk && pulses == 3) && n < 200) begin
      step();
      n++;
    end
    chk("reach bit3", pulses, 3);
    rst = 1'b1;
    #1;
    chk("midrst jp_clk", jp_clk, 0);
    chk("midrst jp_latch", jp_latch, 0);
    chk("midrst jp1", jp1_state, 0);
    chk("midrst jp2", jp2_state, 0);
    chk("midrst busy", busy, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    wait_pv("post reset", 200);
    #1;
    check_poll("post reset", 8'h09, 8'h00, IDLE);

    // Back-to-back polls with pad 1 changing between them.
    btn1 = 8'hFF;
    wait_pv("consec1", 200);
    #1;
    check_poll("consec1", 8'hFF, 8'h00, IDLE);
    btn1 = 8'h10;
    wait_pv("consec2", 200);
    #1;
    check_poll("consec2", 8'h10, 8'h00, IDLE);

    chk("latch&clk overlap", overlap_cnt, 0);
    chk("poll_valid width", pv_wide_cnt, 0);
    chk("state change w/o commit", glitch_cnt, 0);
    chk("jp_clk high width", bad_hi, 0);
    chk("jp_clk low width", bad_lo, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
